// File: rtl/mio_bus_ctrl.sv
// Registered MIO bus controller: decodes the top address bits of one CPU access
// into a one-hot slave select, waits for that slave's ack and reports data/errors.
module mio_bus_ctrl #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int SELW      = 4,
  parameter int NS        = 16,
  parameter int SAW       = 15,
  parameter int TIMEOUT   = 255,
  parameter int ALIGN_CHK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [AW-1:0]    cpu_addr_i,
  input  logic [DW-1:0]    cpu_wdata_i,
  output logic [DW-1:0]    cpu_rdata_o,
  output logic             cpu_ready_o,
  output logic             cpu_err_o,
  output logic [NS-1:0]    s_sel_o,
  output logic             s_we_o,
  output logic [SAW-1:0]   s_addr_o,
  output logic [DW-1:0]    s_wdata_o,
  input  logic [NS*DW-1:0] s_rdata_i,
  input  logic [NS-1:0]    s_ack_i
);

  // Handshake: cpu_req_i is held with stable we/addr/wdata until cpu_ready_o pulses
  // for one cycle; slave i completes by raising s_ack_i[i] while s_sel_o[i] is high.

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [SAW-1:0]   saddr_q;
  logic             we_q;
  logic [DW-1:0]    wdata_q;
  logic [NS-1:0]    sel_q;
  logic             s_we_q;
  logic [DW-1:0]    rdata_q;
  logic             ready_q;
  logic             err_q;

  logic [SELW-1:0]  idx;
  logic [NS-1:0]    sel_dec;
  logic             unmapped;
  logic             misalign;
  logic             ack_hit;
  logic [DW-1:0]    ack_data;
  logic             timeout_hit;
  logic             unused_addr;

  assign unused_addr = ^cpu_addr_i;

  always_comb begin
    idx      = cpu_addr_i[AW-1 -: SELW];
    sel_dec  = '0;
    ack_data = '0;
    for (int i = 0; i < NS; i++) begin
      sel_dec[i] = (idx == SELW'(i));
      if (sel_q[i]) ack_data = ack_data | s_rdata_i[i*DW +: DW];
    end
    // An index with no implemented slave decodes to an all-zero select.
    unmapped    = ~|sel_dec;
    misalign    = (ALIGN_CHK != 0) && (cpu_addr_i[1:0] != 2'b00);
    ack_hit     = |(s_ack_i & sel_q);
    timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      saddr_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      sel_q   <= '0;
      s_we_q  <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (cpu_req_i) begin
            saddr_q <= cpu_addr_i[SAW+1:2];
            we_q    <= cpu_we_i;
            wdata_q <= cpu_wdata_i;
            if (unmapped || misalign) begin
              state_q <= RESP;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              state_q <= ACCESS;
              sel_q   <= sel_dec;
              s_we_q  <= cpu_we_i;
            end
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            state_q <= RESP;
            sel_q   <= '0;
            s_we_q  <= 1'b0;
            rdata_q <= we_q ? '0 : ack_data;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            state_q <= RESP;
            sel_q   <= '0;
            s_we_q  <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdata_o = rdata_q;
  assign cpu_ready_o = ready_q;
  assign cpu_err_o   = err_q;
  assign s_sel_o     = sel_q;
  assign s_we_o      = s_we_q;
  assign s_addr_o    = saddr_q;
  assign s_wdata_o   = wdata_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Bench for mio_bus_ctrl: per-access outcome model feeding a per-cycle expected
// queue, checked on every falling edge, plus directed and random accesses.
module tb_mio_bus_ctrl;

  localparam int DW        = 32;
  localparam int AW        = 32;
  localparam int SELW      = 4;
  localparam int NS        = 15;
  localparam int SAW       = 15;
  localparam int TIMEOUT   = 6;
  localparam int ALIGN_CHK = 1;
  localparam int W         = NS + 1 + SAW + DW + 2 + DW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cpu_req;
  logic             cpu_we;
  logic [AW-1:0]    cpu_addr;
  logic [DW-1:0]    cpu_wdata;
  logic [DW-1:0]    cpu_rdata;
  logic             cpu_ready;
  logic             cpu_err;
  logic [NS-1:0]    s_sel;
  logic             s_we;
  logic [SAW-1:0]   s_addr;
  logic [DW-1:0]    s_wdata;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]    s_ack;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  mio_bus_ctrl #(
    .DW(DW), .AW(AW), .SELW(SELW), .NS(NS), .SAW(SAW),
    .TIMEOUT(TIMEOUT), .ALIGN_CHK(ALIGN_CHK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_ready_o(cpu_ready),
    .cpu_err_o(cpu_err), .s_sel_o(s_sel), .s_we_o(s_we), .s_addr_o(s_addr),
    .s_wdata_o(s_wdata), .s_rdata_i(s_rdata), .s_ack_i(s_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [NS-1:0] sel, input logic we,
                                      input logic [SAW-1:0] sa, input logic [DW-1:0] wd,
                                      input logic rdy, input logic err, input logic [DW-1:0] rd);
    return {sel, we, sa, wd, rdy, err, rd};
  endfunction

  // Compare process: one expected entry per cycle; an empty queue means idle bus.
  logic [W-1:0]   e;
  logic [NS-1:0]  e_sel;
  logic           e_we;
  logic [SAW-1:0] e_sa;
  logic [DW-1:0]  e_wd;
  logic           e_rdy;
  logic           e_err;
  logic [DW-1:0]  e_rd;

  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '0;
      e_rd  = e[DW-1:0];
      e_err = e[DW];
      e_rdy = e[DW+1];
      e_wd  = e[DW+2 +: DW];
      e_sa  = e[2*DW+2 +: SAW];
      e_we  = e[2*DW+2+SAW];
      e_sel = e[2*DW+3+SAW +: NS];
      chk("s_sel", s_sel, e_sel);
      chk("cpu_ready", cpu_ready, e_rdy);
      chk("cpu_err", cpu_err, e_err);
      chk("cpu_rdata", cpu_rdata, e_rd);
      if (e_sel != '0) begin
        chk("s_we", s_we, e_we);
        chk("s_addr", s_addr, e_sa);
        chk("s_wdata", s_wdata, e_wd);
      end
    end
  end

  task automatic drive_noise(input bit all_noise);
    s_ack = all_noise ? '1 : NS'($urandom);
    for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cpu_req = 1'b0;
      drive_noise(0);
      exp_q.push_back('0);
    end
  endtask

  // One access. d = ack-low cycles before the selected slave acks.
  task automatic run_txn(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wd,
                         input int d, input logic [DW-1:0] rd_val, input bit all_noise,
                         output int s_n, output logic err_n, output logic [DW-1:0] rd_n);
    int idx;
    bit dec_err;
    logic [NS-1:0] oh;
    logic [SAW-1:0] sa;
    idx = int'(addr[AW-1 -: SELW]);
    dec_err = (idx >= NS) || (ALIGN_CHK != 0 && addr[1:0] != 2'b00);
    oh = '0;
    if (!dec_err) oh[idx] = 1'b1;
    sa = addr[SAW+1:2];
    if (dec_err) begin
      s_n = 0; err_n = 1'b1;
    end else if (TIMEOUT == 0 || d < TIMEOUT) begin
      s_n = d + 1; err_n = 1'b0;
    end else begin
      s_n = TIMEOUT; err_n = 1'b1;
    end
    rd_n = (we || err_n) ? '0 : rd_val;
    for (int c = 0; c <= s_n + 1; c++) begin
      @(posedge clk); #1;
      cpu_req = (c <= s_n);
      if (c == 0) begin
        cpu_addr = addr; cpu_we = we; cpu_wdata = wd;
      end else begin
        cpu_addr = $urandom; cpu_we = 1'($urandom); cpu_wdata = $urandom;
      end
      drive_noise(all_noise);
      if (!dec_err && c >= 1 && c <= s_n) begin
        s_ack[idx] = (c == d + 1);
        if (c == d + 1) s_rdata[idx*DW +: DW] = rd_val;
      end
      if (c == 0) exp_q.push_back('0);
      else if (c <= s_n) exp_q.push_back(mk(oh, we, sa, wd, 1'b0, 1'b0, '0));
      else exp_q.push_back(mk('0, 1'b0, '0, '0, 1'b1, err_n, rd_n));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sel"}, s_sel, 0);
    chk({tag, "_ready"}, cpu_ready, 0);
    chk({tag, "_err"}, cpu_err, 0);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_we"}, s_we, 0);
    chk({tag, "_addr"}, s_addr, 0);
    chk({tag, "_wdata"}, s_wdata, 0);
  endtask

  task automatic reset_mid_access();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      cpu_req = 1'b1;
      if (c == 0) begin
        cpu_addr = 32'h3000_0040; cpu_we = 1'b0; cpu_wdata = 32'h0;
      end
      drive_noise(0);
      s_ack[3] = 1'b0;
      if (c == 0) exp_q.push_back('0);
      else exp_q.push_back(mk(NS'(1) << 3, 1'b0, SAW'(16), 32'h0, 1'b0, 1'b0, '0));
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int s_n;
    logic e_n;
    logic [DW-1:0] r_n;
    logic [AW-1:0] a;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    s_ack = '0; s_rdata = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_txn(32'h0000_0010, 1'b0, 32'h0, 0, 32'hDEADBEEF, 0, s_n, e_n, r_n);
    chk("t1_lat", s_n, 1); chk("t1_err", e_n, 0); chk("t1_rd", r_n, 32'hDEADBEEF);

    run_txn(32'hE000_0000, 1'b1, 32'h1234_5678, 3, 32'hFFFF_FFFF, 0, s_n, e_n, r_n);
    chk("t2_lat", s_n, 4); chk("t2_err", e_n, 0); chk("t2_rd", r_n, 0);

    run_txn(32'hF000_0000, 1'b0, 32'h0, 0, 32'h1111_1111, 0, s_n, e_n, r_n);
    chk("t3_lat", s_n, 0); chk("t3_err", e_n, 1);

    run_txn(32'h0000_0002, 1'b0, 32'h0, 0, 32'h2222_2222, 0, s_n, e_n, r_n);
    chk("t4_lat", s_n, 0); chk("t4_err", e_n, 1);

    run_txn(32'h1000_0004, 1'b0, 32'h0, 100, 32'h3333_3333, 0, s_n, e_n, r_n);
    chk("t5_lat", s_n, 6); chk("t5_err", e_n, 1); chk("t5_rd", r_n, 0);

    run_txn(32'h1000_0008, 1'b0, 32'h0, 5, 32'h4444_4444, 0, s_n, e_n, r_n);
    chk("t6_lat", s_n, 6); chk("t6_err", e_n, 0); chk("t6_rd", r_n, 32'h4444_4444);

    run_txn(32'h2000_0008, 1'b0, 32'h0, 2, 32'hA5A5_0002, 1, s_n, e_n, r_n);
    chk("t7_lat", s_n, 3); chk("t7_rd", r_n, 32'hA5A5_0002);

    reset_mid_access();
    run_txn(32'h3000_0040, 1'b0, 32'h0, 1, 32'h0BAD_F00D, 0, s_n, e_n, r_n);
    chk("t8_lat", s_n, 2); chk("t8_rd", r_n, 32'h0BAD_F00D);

    for (int k = 0; k < 150; k++) begin
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      run_txn(a, 1'($urandom), $urandom, $urandom_range(0, 8), $urandom,
              ($urandom_range(0, 9) == 0), s_n, e_n, r_n);
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(3);
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
